// File: rtl/fifo_sync_flags.sv
// fifo_sync_flags: single-clock FIFO of any depth >= 2, with occupancy count,
// almost-full/almost-empty thresholds and sticky overflow/underflow errors.
// Ports: clk, reset (async, active low), synch_rst (sync clear, active high);
//   write side data_input/push; read side pop/data_out/data_valid;
//   status full_out, empty_out, almost_full, almost_empty, count,
//   overflow, underflow.
// Build option: define FIFO_FWFT_EN for first-word-fall-through reads
//   (head word shown combinationally). Without it, reads are registered
//   with one cycle of latency.
module fifo_sync_flags #(
    parameter int WORDLENGHT   = 8,
    parameter int Mem_lenght   = 8,
    parameter int AF_THRESHOLD = 6,
    parameter int AE_THRESHOLD = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            synch_rst,
    input  logic [WORDLENGHT-1:0]           data_input,
    input  logic                            push,
    input  logic                            pop,
    output logic [WORDLENGHT-1:0]           data_out,
    output logic                            data_valid,
    output logic                            full_out,
    output logic                            empty_out,
    output logic                            almost_full,
    output logic                            almost_empty,
    output logic [$clog2(Mem_lenght+1)-1:0] count,
    output logic                            overflow,
    output logic                            underflow
);

    localparam int AW = $clog2(Mem_lenght);
    localparam int CW = $clog2(Mem_lenght + 1);

    logic [WORDLENGHT-1:0] mem_q [Mem_lenght];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          af_q, af_d;
    logic          ae_q, ae_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          push_ok, pop_ok;

    // A pop frees a slot in the same edge, so a full FIFO still accepts
    // a push that is paired with a successful pop.
    assign pop_ok  = pop & ~empty_q;
    assign push_ok = push & (~full_q | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (push & ~push_ok);
        udf_d    = udf_q | (pop & ~pop_ok);

        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == AW'(Mem_lenght - 1)) ? '0 : wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == AW'(Mem_lenght - 1)) ? '0 : rd_ptr_q + AW'(1);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (synch_rst) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end

        // Flags track the next count so they are correct right after the edge.
        full_d  = (count_d == CW'(Mem_lenght));
        empty_d = (count_d == '0);
        af_d    = (count_d >= CW'(AF_THRESHOLD));
        ae_d    = (count_d <= CW'(AE_THRESHOLD));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (push_ok && !synch_rst) begin
            mem_q[wr_ptr_q] <= data_input;
        end
    end

`ifdef FIFO_FWFT_EN
    assign data_out   = mem_q[rd_ptr_q];
    assign data_valid = ~empty_q;
`else
    logic [WORDLENGHT-1:0] data_q, data_d;
    logic                  valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = 1'b0;
        if (synch_rst) begin
            data_d = '0;
        end else if (pop_ok) begin
            data_d  = mem_q[rd_ptr_q];
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
`endif

    assign full_out     = full_q;
    assign empty_out    = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// tb_fifo_sync_flags: directed checks of fifo_sync_flags in depth 8 and depth 5.
// Honours FIFO_FWFT_EN to pick read-timing expectations.
module tb_fifo_sync_flags;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       synch_rst = 1'b0;

    logic [7:0] din = '0;
    logic       push = 1'b0, pop = 1'b0;
    logic [7:0] data_out;
    logic       data_valid, full_out, empty_out;
    logic       almost_full, almost_empty, overflow, underflow;
    logic [3:0] count;

    logic [7:0] din5 = '0;
    logic       push5 = 1'b0, pop5 = 1'b0;
    logic [7:0] data_out5;
    logic       data_valid5, full5, empty5, af5, ae5, ovf5, udf5;
    logic [2:0] count5;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    fifo_sync_flags #(
        .WORDLENGHT(8), .Mem_lenght(8), .AF_THRESHOLD(6), .AE_THRESHOLD(2)
    ) u_dut (
        .clk(clk), .reset(reset), .synch_rst(synch_rst),
        .data_input(din), .push(push), .pop(pop),
        .data_out(data_out), .data_valid(data_valid),
        .full_out(full_out), .empty_out(empty_out),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    fifo_sync_flags #(
        .WORDLENGHT(8), .Mem_lenght(5), .AF_THRESHOLD(4), .AE_THRESHOLD(1)
    ) u_dut5 (
        .clk(clk), .reset(reset), .synch_rst(synch_rst),
        .data_input(din5), .push(push5), .pop(pop5),
        .data_out(data_out5), .data_valid(data_valid5),
        .full_out(full5), .empty_out(empty5),
        .almost_full(af5), .almost_empty(ae5),
        .count(count5), .overflow(ovf5), .underflow(udf5)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_srst();
        push = 0; pop = 0; synch_rst = 1;
        step();
        synch_rst = 0;
    endtask

    task automatic test_reset();
        reset = 0;
        step(); step();
        reset = 1;
        step();
        nvec++;
        if (count !== 4'd0 || empty_out !== 1'b1 || full_out !== 1'b0) begin
            nerr++;
            $display("FAIL reset_state: cnt=%0d e=%b f=%b want 0 1 0", count, empty_out, full_out);
        end
        nvec++;
        if (almost_empty !== 1'b1 || almost_full !== 1'b0 || overflow !== 1'b0 ||
            underflow !== 1'b0 || data_valid !== 1'b0) begin
            nerr++;
            $display("FAIL reset_flags: ae=%b af=%b ov=%b un=%b dv=%b want 1 0 0 0 0",
                     almost_empty, almost_full, overflow, underflow, data_valid);
        end
`ifndef FIFO_FWFT_EN
        nvec++;
        if (data_out !== 8'h00) begin
            nerr++;
            $display("FAIL reset_dout: got %h want 00", data_out);
        end
`endif
        for (int i = 0; i < 5; i++) begin
            push = 1; din = 8'(8'h20 + i);
            step();
        end
        push = 0;
        nvec++;
        if (count !== 4'd5) begin
            nerr++;
            $display("FAIL pre_reset_count: got %0d want 5", count);
        end
        reset = 0;
        #1;
        nvec++;
        if (count !== 4'd0 || empty_out !== 1'b1 || almost_empty !== 1'b1 ||
            almost_full !== 1'b0 || data_valid !== 1'b0) begin
            nerr++;
            $display("FAIL async_reset: cnt=%0d e=%b ae=%b af=%b dv=%b want 0 1 1 0 0",
                     count, empty_out, almost_empty, almost_full, data_valid);
        end
        #1;
        reset = 1;
        step();
    endtask

    task automatic test_fill_drain();
        logic [7:0] got;
        logic       v;
        do_srst();
        for (int i = 1; i <= 8; i++) begin
            push = 1; din = 8'(i);
            step();
            nvec++;
            if (count !== 4'(i) || full_out !== (i == 8)) begin
                nerr++;
                $display("FAIL fill_count[%0d]: cnt=%0d f=%b want %0d %b", i, count, full_out, i, (i == 8));
            end
            nvec++;
            if (almost_full !== (i >= 6) || almost_empty !== (i <= 2)) begin
                nerr++;
                $display("FAIL fill_thr[%0d]: af=%b ae=%b want %b %b", i, almost_full, almost_empty, (i >= 6), (i <= 2));
            end
        end
        din = 8'h09;
        step();
        push = 0;
        nvec++;
        if (overflow !== 1'b1 || count !== 4'd8 || full_out !== 1'b1) begin
            nerr++;
            $display("FAIL overflow: ov=%b cnt=%0d f=%b want 1 8 1", overflow, count, full_out);
        end
        for (int i = 1; i <= 8; i++) begin
`ifdef FIFO_FWFT_EN
            got = data_out; v = data_valid;
            pop = 1; step();
`else
            pop = 1; step();
            got = data_out; v = data_valid;
`endif
            nvec++;
            if (got !== 8'(i) || v !== 1'b1 || count !== 4'(8 - i)) begin
                nerr++;
                $display("FAIL drain[%0d]: d=%h v=%b cnt=%0d want %h 1 %0d", i, got, v, count, 8'(i), 8 - i);
            end
        end
        pop = 0;
        step();
        nvec++;
        if (data_valid !== 1'b0 || empty_out !== 1'b1 || overflow !== 1'b1) begin
            nerr++;
            $display("FAIL drained: dv=%b e=%b ov=%b want 0 1 1", data_valid, empty_out, overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] got;
        logic       v;
        logic [7:0] exp;
        do_srst();
        for (int i = 1; i <= 8; i++) begin
            push = 1; din = 8'(i);
            step();
        end
        din = 8'hAA;
`ifdef FIFO_FWFT_EN
        got = data_out; v = data_valid;
        pop = 1; step();
`else
        pop = 1; step();
        got = data_out; v = data_valid;
`endif
        push = 0; pop = 0;
        nvec++;
        if (got !== 8'h01 || v !== 1'b1 || count !== 4'd8 || full_out !== 1'b1 || overflow !== 1'b0) begin
            nerr++;
            $display("FAIL full_pushpop: d=%h v=%b cnt=%0d f=%b ov=%b want 01 1 8 1 0",
                     got, v, count, full_out, overflow);
        end
        for (int i = 2; i <= 9; i++) begin
            exp = (i == 9) ? 8'hAA : 8'(i);
`ifdef FIFO_FWFT_EN
            got = data_out;
            pop = 1; step();
`else
            pop = 1; step();
            got = data_out;
`endif
            nvec++;
            if (got !== exp) begin
                nerr++;
                $display("FAIL wrap_order[%0d]: got %h want %h", i, got, exp);
            end
        end
        pop = 0;
        step();
    endtask

    task automatic test_underflow();
        do_srst();
        pop = 1;
        step();
        pop = 0;
        nvec++;
        if (underflow !== 1'b1 || count !== 4'd0 || empty_out !== 1'b1) begin
            nerr++;
            $display("FAIL underflow: un=%b cnt=%0d e=%b want 1 0 1", underflow, count, empty_out);
        end
        push = 1; pop = 1; din = 8'h55;
        step();
        push = 0; pop = 0;
        nvec++;
        if (count !== 4'd1 || empty_out !== 1'b0 || underflow !== 1'b1) begin
            nerr++;
            $display("FAIL empty_pushpop: cnt=%0d e=%b un=%b want 1 0 1", count, empty_out, underflow);
        end
        push = 1; din = 8'h66; synch_rst = 1;
        step();
        push = 0; synch_rst = 0;
        nvec++;
        if (underflow !== 1'b0 || count !== 4'd0 || empty_out !== 1'b1 || almost_empty !== 1'b1) begin
            nerr++;
            $display("FAIL synch_rst: un=%b cnt=%0d e=%b ae=%b want 0 0 1 1",
                     underflow, count, empty_out, almost_empty);
        end
    endtask

    task automatic test_stream_depth5();
        logic [7:0] got;
        push5 = 1; din5 = 8'h10;
        step();
        for (int k = 1; k <= 13; k++) begin
            push5 = (k <= 12);
            din5  = 8'(8'h10 + k);
`ifdef FIFO_FWFT_EN
            got = data_out5;
            pop5 = 1; step();
`else
            pop5 = 1; step();
            got = data_out5;
`endif
            nvec++;
            if (got !== 8'(8'h10 + k - 1) || count5 !== ((k <= 12) ? 3'd1 : 3'd0)) begin
                nerr++;
                $display("FAIL stream5[%0d]: d=%h cnt=%0d want %h %0d",
                         k, got, count5, 8'(8'h10 + k - 1), (k <= 12) ? 1 : 0);
            end
        end
        push5 = 0; pop5 = 0;
        step();
        nvec++;
        if (empty5 !== 1'b1 || ovf5 !== 1'b0 || udf5 !== 1'b0) begin
            nerr++;
            $display("FAIL stream5_end: e=%b ov=%b un=%b want 1 0 0", empty5, ovf5, udf5);
        end
    endtask

`ifdef FIFO_FWFT_EN
    task automatic test_read_timing();
        do_srst();
        push = 1; din = 8'h3C;
        step();
        push = 0;
        step();
        nvec++;
        if (data_out !== 8'h3C || data_valid !== 1'b1) begin
            nerr++;
            $display("FAIL fwft_head: d=%h dv=%b want 3c 1", data_out, data_valid);
        end
        pop = 1;
        step();
        pop = 0;
        nvec++;
        if (empty_out !== 1'b1 || data_valid !== 1'b0) begin
            nerr++;
            $display("FAIL fwft_pop: e=%b dv=%b want 1 0", empty_out, data_valid);
        end
    endtask
`else
    task automatic test_read_timing();
        do_srst();
        push = 1; din = 8'h3C;
        step();
        push = 0;
        nvec++;
        if (data_valid !== 1'b0 || data_out !== 8'h00) begin
            nerr++;
            $display("FAIL std_nopop: d=%h dv=%b want 00 0", data_out, data_valid);
        end
        pop = 1;
        step();
        pop = 0;
        nvec++;
        if (data_out !== 8'h3C || data_valid !== 1'b1) begin
            nerr++;
            $display("FAIL std_pop: d=%h dv=%b want 3c 1", data_out, data_valid);
        end
        step();
        nvec++;
        if (data_out !== 8'h3C || data_valid !== 1'b0 || empty_out !== 1'b1) begin
            nerr++;
            $display("FAIL std_hold: d=%h dv=%b e=%b want 3c 0 1", data_out, data_valid, empty_out);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fill_drain();
        test_full_push_pop();
        test_underflow();
        test_stream_depth5();
        test_read_timing();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
